// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the pipeline, the memory access controller and the data memory.
// The controller connects through the slave modport; the pipeline/memory side uses master.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, mem_rd_data, mem_ready,
        output stall, resp_valid, resp_rdata, err,
        mem_valid, mem_rw, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, mem_rd_data, mem_ready,
        input  stall, resp_valid, resp_rdata, err,
        mem_valid, mem_rw, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the pipeline and a handshaked data memory.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for req_valid; accepts or rejects a request
// REQ   | mem_valid held with stable mem_* until mem_ready (or timeout)
// DONE  | resp_valid high for one cycle, then back to IDLE
module mem_access_ctrl #(
    parameter int ADDR_LIMIT     = 4112,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);

    localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        reject;
    logic        mem_done;
    logic        timeout;
    logic        mem_valid_d;
    logic        mem_rw_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_wr_data_d;
    logic        resp_valid_d;
    logic [31:0] resp_rdata_d;
    logic        err_d;

    always_comb begin
        accept   = (state == IDLE) && bus.req_valid && (bus.req_addr < LIMIT);
        reject   = (state == IDLE) && bus.req_valid && !(bus.req_addr < LIMIT);
        mem_done = (state == REQ) && bus.mem_ready;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] req_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt <= '0;
        end else if (accept) begin
            req_cnt <= '0;
        end else if (state == REQ) begin
            req_cnt <= req_cnt + 1'b1;
        end
    end

    // Abort at the end of the TIMEOUT_CYCLES-th REQ cycle; a ready in that same cycle still wins.
    assign timeout = (state == REQ) && !bus.mem_ready && (req_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.mem_valid   <= 1'b0;
            bus.mem_rw      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.err         <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.mem_valid   <= mem_valid_d;
            bus.mem_rw      <= mem_rw_d;
            bus.mem_addr    <= mem_addr_d;
            bus.mem_wr_data <= mem_wr_data_d;
            bus.resp_valid  <= resp_valid_d;
            bus.resp_rdata  <= resp_rdata_d;
            bus.err         <= err_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
                     else if (reject) state_nxt = DONE;
            REQ:     if (mem_done || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_valid_d   = bus.mem_valid;
        mem_rw_d      = bus.mem_rw;
        mem_addr_d    = bus.mem_addr;
        mem_wr_data_d = bus.mem_wr_data;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = bus.resp_rdata;
        err_d         = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mem_valid_d   = 1'b1;
                    mem_rw_d      = bus.req_rw;
                    mem_addr_d    = bus.req_addr;
                    mem_wr_data_d = bus.req_wdata;
                end else if (reject) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    err_d        = 1'b1;
                end
            end
            REQ: begin
                if (mem_done) begin
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!bus.mem_rw) resp_rdata_d = bus.mem_rd_data;
                end else if (timeout) begin
                    mem_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    err_d        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset forces stall low even if the pipeline keeps req_valid asserted.
    assign bus.stall = !rst && (((state == IDLE) && bus.req_valid) || (state == REQ));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a two-cycle-handshake memory model.
// Checks load, store, address limit, back-to-back, stall and reset behaviour.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_access = 0;
    int n_writes = 0;
    int wait_cnt = 0;
    bit mem_auto = 1'b1;
    logic [31:0] mem [0:4111];

    // Memory answers one full cycle after it first sees mem_valid.
    always @(negedge clk) begin
        if (mem_auto) begin
            if (bus.mem_valid && !bus.mem_ready) begin
                if (wait_cnt == 1) begin
                    wait_cnt = 0;
                    bus.mem_ready = 1'b1;
                    n_access++;
                    if (bus.mem_rw) begin
                        n_writes++;
                        if (bus.mem_addr < 32'd4112) mem[bus.mem_addr[12:0]] = bus.mem_wr_data;
                    end else begin
                        bus.mem_rd_data = (bus.mem_addr < 32'd4112) ? mem[bus.mem_addr[12:0]] : 32'hBAD0_BAD0;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one request from IDLE, wait (bounded) for resp_valid, then step back to IDLE.
    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic e, output int lat,
                          output logic rv_after, output logic saw_mv);
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        lat    = 0;
        saw_mv = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 1) bus.req_valid = 1'b0;
            saw_mv = saw_mv | bus.mem_valid;
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("resp_valid_timeout", 32'd0, 32'd1);
        rdata = bus.resp_rdata;
        e     = bus.err;
        tick();
        rv_after = bus.resp_valid;
    endtask

    logic [31:0] rdata;
    logic        e;
    logic        rv_after;
    logic        saw_mv;
    logic        flag;
    int          lat;
    int          acc0;
    int          wr0;
    int          nmv;
    logic [31:0] b2b_addr [3];

    initial begin
        for (int i = 0; i < 4112; i++) mem[i] = 32'h0;
        mem[1]    = 32'h0000_0001;
        mem[16]   = 32'h0000_00A0;
        mem[17]   = 32'h0000_00A1;
        mem[18]   = 32'h0000_00A2;
        mem[4111] = 32'h0000_1234;
        b2b_addr[0] = 32'h10;
        b2b_addr[1] = 32'h11;
        b2b_addr[2] = 32'h12;

        rst = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_rw      = 1'b0;
        bus.req_addr    = 32'h1;
        bus.req_wdata   = 32'h0;
        bus.mem_rd_data = 32'h0;
        bus.mem_ready   = 1'b0;
        tick();
        tick();
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Load from address 1, cycle by cycle
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = 32'h1;
        #1;
        check("ld_stall_idle", 32'(bus.stall), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("ld_mv_c1", 32'(bus.mem_valid), 32'd1);
        check("ld_addr_c1", bus.mem_addr, 32'h1);
        check("ld_rw_c1", 32'(bus.mem_rw), 32'd0);
        check("ld_stall_c1", 32'(bus.stall), 32'd1);
        check("ld_rv_c1", 32'(bus.resp_valid), 32'd0);
        tick();
        check("ld_mv_c2", 32'(bus.mem_valid), 32'd1);
        check("ld_stall_c2", 32'(bus.stall), 32'd1);
        tick();
        check("ld_mv_c3", 32'(bus.mem_valid), 32'd0);
        check("ld_rv_c3", 32'(bus.resp_valid), 32'd1);
        check("ld_rdata", bus.resp_rdata, 32'h0000_0001);
        check("ld_err", 32'(bus.err), 32'd0);
        check("ld_stall_c3", 32'(bus.stall), 32'd0);
        tick();
        check("ld_rv_c4", 32'(bus.resp_valid), 32'd0);

        // Store then load back
        wr0 = n_writes;
        do_req(1'b1, 32'h20, 32'hDEAD_BEEF, rdata, e, lat, rv_after, saw_mv);
        check("st_lat", 32'(lat), 32'd3);
        check("st_rdata_kept", rdata, 32'h0000_0001);
        check("st_err", 32'(e), 32'd0);
        check("st_mem", mem[32], 32'hDEAD_BEEF);
        do_req(1'b0, 32'h20, 32'h0, rdata, e, lat, rv_after, saw_mv);
        check("st_ld_rdata", rdata, 32'hDEAD_BEEF);
        check("st_ld_rv_once", 32'(rv_after), 32'd0);
        check("st_writes", 32'(n_writes - wr0), 32'd1);

        // Address limit: 4112 rejected, 4111 accepted
        acc0 = n_access;
        do_req(1'b0, 32'd4112, 32'h0, rdata, e, lat, rv_after, saw_mv);
        check("oor_lat", 32'(lat), 32'd1);
        check("oor_err", 32'(e), 32'd1);
        check("oor_rdata", rdata, 32'h0);
        check("oor_no_mv", 32'(saw_mv), 32'd0);
        check("oor_rv_once", 32'(rv_after), 32'd0);
        check("oor_err_clr", 32'(bus.err), 32'd0);
        check("oor_no_access", 32'(n_access - acc0), 32'd0);
        do_req(1'b0, 32'd4111, 32'h0, rdata, e, lat, rv_after, saw_mv);
        check("lim_lat", 32'(lat), 32'd3);
        check("lim_err", 32'(e), 32'd0);
        check("lim_rdata", rdata, 32'h0000_1234);

        // Back-to-back with req_valid held; junk address while busy must be ignored
        acc0 = n_access;
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b0;
        bus.req_addr  = b2b_addr[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_mv_c1", 32'(bus.mem_valid), 32'd1);
            check("b2b_addr_c1", bus.mem_addr, b2b_addr[i]);
            bus.req_addr = 32'h0ABC;
            tick();
            check("b2b_addr_c2", bus.mem_addr, b2b_addr[i]);
            tick();
            check("b2b_rv", 32'(bus.resp_valid), 32'd1);
            check("b2b_rdata", bus.resp_rdata, 32'h0000_00A0 + 32'(i));
            if (i < 2) bus.req_addr = b2b_addr[i + 1];
            else bus.req_valid = 1'b0;
            tick();
            check("b2b_bubble_mv", 32'(bus.mem_valid), 32'd0);
            check("b2b_bubble_rv", 32'(bus.resp_valid), 32'd0);
        end
        check("b2b_accesses", 32'(n_access - acc0), 32'd3);

        // Memory never answers
        mem_auto = 1'b0;
        bus.mem_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h5;
        tick();
        bus.req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
        nmv = (bus.mem_valid) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!bus.mem_valid) break;
            nmv++;
        end
        check("to_mv_cycles", 32'(nmv), 32'd16);
        check("to_rv", 32'(bus.resp_valid), 32'd1);
        check("to_err", 32'(bus.err), 32'd1);
        check("to_rdata", bus.resp_rdata, 32'h0);
        tick();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h5;
        tick();
        bus.req_valid = 1'b0;
`else
        nmv = 0;
        flag = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!bus.mem_valid || bus.resp_valid) flag = 1'b1;
        end
        check("wait_forever", 32'(flag), 32'd0);
`endif

        // Reset while the access is pending
        check("mid_mv_before_rst", 32'(bus.mem_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_mv", 32'(bus.mem_valid), 32'd0);
        check("mid_rst_stall", 32'(bus.stall), 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'h0);
        check("mid_rst_rdata", bus.resp_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) bus.mem_ready = 1'b0;
            if (bus.resp_valid || bus.mem_valid) flag = 1'b1;
        end
        check("stray_ready_ignored", 32'(flag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_LIMIT, default 4112, SHALL be the number of valid word addresses in data memory.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL be the cycles waited in REQ for mem_ready before abort (used only with MEM_TIMEOUT_EN).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mark a pipeline load/store request.
REQ-006 req_rw  in  1  SHALL select the operation: 1 = store, 0 = load.
REQ-007 req_addr  in  32  SHALL carry the word address.
REQ-008 req_wdata  in  32  SHALL carry the store data.
REQ-009 stall  out  1  SHALL hold the pipeline while an access is in progress.
REQ-010 resp_valid  out  1  SHALL pulse for one cycle when an access completes.
REQ-011 resp_rdata  out  32  SHALL carry the load result.
REQ-012 err  out  1  SHALL flag a failed access; qualified by resp_valid.
REQ-013 mem_valid, mem_rw  out  1 each  SHALL drive the data memory request.
REQ-014 mem_addr, mem_wr_data  out  32 each  SHALL drive the data memory address and write data.
REQ-015 mem_rd_data  in  32, mem_ready  in  1  SHALL be the data memory read data and completion strobe.

Function
REQ-016 States SHALL be IDLE, REQ and DONE; all mem_* and resp_* outputs SHALL be registered.
REQ-017 IDLE, req_valid=1, req_addr < ADDR_LIMIT: latch rw/addr/wdata onto mem_*, set mem_valid=1, go to REQ.
REQ-018 IDLE, req_valid=1, req_addr >= ADDR_LIMIT: no memory access, mem_valid stays 0, go to DONE with err=1 and resp_rdata=0.
REQ-019 REQ: mem_valid and mem_* SHALL hold stable until mem_ready=1 is sampled.
REQ-020 REQ, mem_ready=1: clear mem_valid at that edge; on a load, capture mem_rd_data into resp_rdata; go to DONE.
REQ-021 DONE: resp_valid=1 for exactly one cycle, then go to IDLE unconditionally; a store SHALL leave resp_rdata unchanged and err=0.
REQ-022 stall SHALL be combinational: 1 when (IDLE and req_valid) or REQ; 0 in DONE.
REQ-023 A new request SHALL be accepted only in IDLE; req_valid in REQ or DONE SHALL be ignored.
REQ-024 mem_ready sampled in IDLE or DONE SHALL be ignored.
REQ-025 With a 1-cycle memory, latency SHALL be: accept at edge E0, mem_ready seen at E2, resp_valid high between E2 and E3.
REQ-026 mem_valid SHALL never be high for two cycles after a sampled mem_ready, so the memory never performs a duplicate access.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and set stall, resp_valid, err, mem_valid and mem_rw to 0; mem_addr, mem_wr_data and resp_rdata SHALL be set to 0.
REQ-028 Reset in REQ SHALL abandon the access; a later stray mem_ready SHALL be ignored per REQ-024.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ and increment each REQ cycle; if it reaches TIMEOUT_CYCLES with no mem_ready, clear mem_valid and go to DONE with err=1 and resp_rdata=0.
REQ-030 Macro MEM_TIMEOUT_EN undefined: no counter SHALL be present; REQ SHALL wait indefinitely, and err SHALL arise only from REQ-018.

Verification
REQ-031 Load: mem[1]=0x1, req addr=1, rw=0 -> mem_valid high for 2 cycles; resp_valid one cycle later with resp_rdata=0x00000001, err=0; stall high for 3 cycles.
REQ-032 Store then load: store 0xDEADBEEF to addr 0x20, then load 0x20 -> second resp_rdata=0xDEADBEEF; exactly one memory write observed.
REQ-033 Out of range: req addr=4112 -> no mem_valid; resp_valid next cycle with err=1 and resp_rdata=0.
REQ-034 Back-to-back: req_valid held with changing addresses -> one IDLE bubble between accesses; each access issued exactly once.
REQ-035 Reset mid-REQ: rst asserted while mem_valid=1 -> mem_valid=0 and stall=0 without waiting for a clock edge; a stray mem_ready afterwards produces no resp_valid.
REQ-036 MEM_TIMEOUT_EN, memory model holds mem_ready=0 -> after 16 REQ cycles mem_valid drops; resp_valid with err=1 and resp_rdata=0.
